// File: rtl/dds_cmd_parser.sv
// Byte-command decoder for a bank of DDS channels: shadowed tuning-word writes,
// atomic SET commit, enables, readback and ACK/NAK responses over a UART link.
module dds_cmd_parser #(
  parameter int          NUM_CH         = 4,
  parameter int          WORD_BYTES     = 4,
  parameter int          TIMEOUT_CYCLES = 1200000,
  parameter logic [7:0]  ACK            = 8'h06,
  parameter logic [7:0]  NAK            = 8'h15,
  localparam int         W              = 8 * WORD_BYTES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                received,
  input  logic [7:0]          rx_byte,
  input  logic                tx_busy,
  output logic                transmit,
  output logic [7:0]          tx_byte,
  output logic [NUM_CH-1:0]   en,
  output logic [NUM_CH*W-1:0] m,
  output logic                set,
  output logic                error
);

  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST = IW'(WORD_BYTES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, READ_TX, RESP} state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [CW-1:0]              ch_q, ch_d;
  logic [TW-1:0]              cnt_q, cnt_d;
  logic [7:0]                 resp_q, resp_d;
  logic [W-1:0]               asm_q, asm_d;
  logic [NUM_CH-1:0][W-1:0]   shadow_q, shadow_d;
  logic [NUM_CH-1:0][W-1:0]   m_q, m_d;
  logic [NUM_CH-1:0]          en_q, en_d;
  logic                       set_q, set_d;
  logic                       error_q, error_d;
  logic [7:0]                 tx_byte_q, tx_byte_d;
  logic                       gap_q;
  logic [7:0]                 cur_byte;
  logic                       tx_ok;

  logic [3:0]    opcode;
  logic [CW-1:0] ch_in;
  logic          cmd_bad;

  assign opcode  = rx_byte[7:4];
  assign ch_in   = rx_byte[CW-1:0];
  assign cmd_bad = (opcode < 4'h1) || (opcode > 4'h5) ||
                   ((opcode != 4'h4) && ({1'b0, rx_byte[3:0]} >= 5'(NUM_CH)));

  // A strobe needs an idle transmitter and at least one quiet cycle after the last strobe.
  assign tx_ok = !tx_busy && !gap_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    asm_d     = asm_q;
    shadow_d  = shadow_q;
    m_d       = m_q;
    en_d      = en_q;
    set_d     = 1'b0;
    error_d   = error_q;
    transmit  = 1'b0;
    cur_byte  = resp_q;
    if (received) error_d = 1'b0;
    case (state_q)
      IDLE: if (received) begin
        ch_d  = ch_in;
        idx_d = '0;
        cnt_d = '0;
        resp_d  = ACK;
        state_d = RESP;
        if (cmd_bad) begin
          error_d = 1'b1;
          resp_d  = NAK;
        end else begin
          case (opcode)
            4'h1:    state_d = PAYLOAD;
            4'h2:    en_d[ch_in] = 1'b1;
            4'h3:    en_d[ch_in] = 1'b0;
            4'h4: begin
              m_d   = shadow_q;
              set_d = 1'b1;
            end
            default: state_d = READ_TX;
          endcase
        end
      end
      PAYLOAD: begin
        if (received) begin
          cnt_d = '0;
          asm_d[{idx_q, 3'b000} +: 8] = rx_byte;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST) begin
            shadow_d[ch_q] = asm_d;
            resp_d  = ACK;
            state_d = RESP;
          end
        end else if (cnt_q == TMAX) begin
          error_d = 1'b1;
          resp_d  = NAK;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READ_TX: begin
        cur_byte = m_q[ch_q][{idx_q, 3'b000} +: 8];
        if (tx_ok) begin
          transmit = 1'b1;
          idx_d    = idx_q + 1'b1;
          if (idx_q == LAST) begin
            resp_d  = ACK;
            state_d = RESP;
          end
        end
      end
      default: if (tx_ok) begin
        transmit = 1'b1;
        state_d  = IDLE;
      end
    endcase
    tx_byte   = transmit ? cur_byte : tx_byte_q;
    tx_byte_d = tx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ch_q      <= '0;
      cnt_q     <= '0;
      resp_q    <= '0;
      asm_q     <= '0;
      shadow_q  <= '0;
      m_q       <= '0;
      en_q      <= '0;
      set_q     <= 1'b0;
      error_q   <= 1'b0;
      tx_byte_q <= '0;
      gap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      resp_q    <= resp_d;
      asm_q     <= asm_d;
      shadow_q  <= shadow_d;
      m_q       <= m_d;
      en_q      <= en_d;
      set_q     <= set_d;
      error_q   <= error_d;
      tx_byte_q <= tx_byte_d;
      gap_q     <= transmit;
    end
  end

  assign en    = en_q;
  assign m     = m_q;
  assign set   = set_q;
  assign error = error_q;

endmodule
